d_ff_enabled: RTL and testbench

- Single-clock, synchronously reset D flip-flop with a load enable, built as a 2:1 select feeding a plain D flop.
- Leaf storage cell of the register file: a 64-bit register instantiates 64 of these, one per bit.
- Each instance ties `d1` to its own `q`, so the stored value holds when the enable is low.
- `d1` is a real input, not internal feedback, so the cell can also act as a "select d or d1, then register" element.

---
 rtl/d_ff_enabled_pkg.sv | 7 +
 rtl/d_ff_enabled_d_ff.sv | 24 ++
 rtl/d_ff_enabled_mux2_1.sv | 14 +
 rtl/d_ff_enabled.sv | 39 +++
 tb/tb_d_ff_enabled.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/d_ff_enabled_pkg.sv
// Shared constants for the register-file storage slice.
// The cell itself is width-parameterised; DATA_WIDTH sizes the enclosing register.
package d_ff_enabled_pkg;

  localparam int unsigned DATA_WIDTH = 64;

endpackage : d_ff_enabled_pkg

// File: rtl/d_ff_enabled_d_ff.sv
// Plain D flop with synchronous active-high clear.
module d_ff_enabled_d_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Storage register: clear wins over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule : d_ff_enabled_d_ff

// File: rtl/d_ff_enabled_mux2_1.sv
// Combinational 2:1 select: out = sel ? i1 : i0.
// The conditional operator is kept so an unknown sel merges differing inputs to X.
module d_ff_enabled_mux2_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? i1 : i0;

endmodule : d_ff_enabled_mux2_1

// File: rtl/d_ff_enabled.sv
// Enabled D flip-flop: per bit, a 2:1 select (d when enabler, else d1) feeding a
// synchronous-reset flop. Tie d1 to q for a hold-when-disabled register bit.
module d_ff_enabled
  import d_ff_enabled_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] d1,
  input  logic             enabler,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sel_s;

  // Bits are independent, so each gets its own mux/flop pair.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_enabled_mux2_1 #(
      .WIDTH(1)
    ) u_mux (
      .i0  (d1[i]),
      .i1  (d[i]),
      .sel (enabler),
      .out (sel_s[i])
    );

    d_ff_enabled_d_ff #(
      .WIDTH(1)
    ) u_ff (
      .clk   (clk),
      .reset (reset),
      .d     (sel_s[i]),
      .q     (q[i])
    );
  end

endmodule : d_ff_enabled

// File: tb/tb_d_ff_enabled.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares just after every rising edge. A WIDTH=4 instance rides along.
module tb_d_ff_enabled;

  typedef struct {
    logic       q1;
    logic [3:0] q4;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enabler;
  logic       d;
  logic       d1;
  logic       d1_drv;
  logic       tie;
  logic       q1;
  logic [3:0] d4;
  logic [3:0] d14;
  logic [3:0] q4;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   pass_checks  = 0;
  int   vec_idx      = 0;

  always #20 clk = ~clk;

  assign d1 = tie ? q1 : d1_drv;

  d_ff_enabled #(.WIDTH(1)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .d1      (d1),
    .enabler (enabler),
    .q       (q1)
  );

  d_ff_enabled #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .d       (d4),
    .d1      (d14),
    .enabler (enabler),
    .q       (q4)
  );

  // Monitor: compare both outputs against the oldest expectation after each edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_checks++;
      if (q1 !== e.q1 || q4 !== e.q4) begin
        $display("FAIL edge_check t=%0t q=%b q4=%h required q=%b q4=%h",
                 $time, q1, q4, e.q1, e.q4);
      end else begin
        pass_checks++;
      end
    end
  end

  // Drive one vector at the falling edge and record what the next rising edge must give.
  task automatic step(input logic r, input logic e, input logic dv,
                      input logic d1v, input logic tv, input logic ex);
    exp_t x;
    @(negedge clk);
    vec_idx++;
    reset   = r;
    enabler = e;
    d       = dv;
    d1_drv  = d1v;
    tie     = tv;
    d4      = 4'(vec_idx) ^ 4'h9;
    d14     = 4'hF - 4'(vec_idx);
    x.q1 = ex;
    x.q4 = r ? 4'h0 : (e ? d4 : d14);
    exp_q.push_back(x);
  endtask

  initial begin
    exp_t x;
    int   wait_cycles;
    reset = 1'b0; enabler = 1'b0; d = 1'b0; d1_drv = 1'b0; tie = 1'b0;
    d4 = 4'h0; d14 = 4'h0;

    // reset with enabler=1 and d=1 still clears
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // hold zero after release
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // load and hold
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // enable gating: d toggles, q stays 0
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // d1 chosen independently of q
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset priority at the same edge, then release
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    // hold 1, then change inputs 10 ns after the edge
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #10;
    enabler = 1'b1; d = 1'b0; tie = 1'b0;
    d4 = 4'h6; d14 = 4'h3;
    x.q1 = 1'b0;
    x.q4 = 4'h6;
    exp_q.push_back(x);
    #5;
    total_checks++;
    if (q1 !== 1'b1 || q4 !== 4'hF - 4'(vec_idx)) begin
      $display("FAIL mid_cycle_stable q=%b q4=%h required q=1 q4=%h",
               q1, q4, 4'hF - 4'(vec_idx));
    end else begin
      pass_checks++;
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total_checks++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule : tb_d_ff_enabled
